// File: rtl/instr_sequencer.sv
// Instruction sequencer: a multi-cycle control FSM that steps one instruction
// through fetch, decode, execute, optional data-memory access and writeback.
// It produces the stage enables, the branch PC load, sticky status flags and
// a count of retired instructions. Data-memory waits are bounded: a LOAD or
// STORE that sees no mem_ready for MEM_TIMEOUT cycles halts with mem_error.
module instr_sequencer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic [2:0]  opclass,
    input  logic        branch_taken,
    input  logic        mem_ready,
    output logic        en_ProgMem,
    output logic        en_Fetch,
    output logic        en_Decode,
    output logic        en_Execute,
    output logic        en_Mem,
    output logic        en_Writeback,
    output logic        pc_load,
    output logic [2:0]  state,
    output logic        halted,
    output logic        illegal_op,
    output logic        mem_error,
    output logic [15:0] instr_count
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEM       = 3'd4,
        S_WRITEBACK = 3'd5,
        S_HALT      = 3'd6,
        S_BAD       = 3'd7
    } state_t;

    localparam logic [2:0] OP_ALU    = 3'd0;
    localparam logic [2:0] OP_LOAD   = 3'd1;
    localparam logic [2:0] OP_STORE  = 3'd2;
    localparam logic [2:0] OP_BRANCH = 3'd3;
    localparam logic [2:0] OP_HALT   = 3'd4;

    // Wait-counter value seen on the last MEM cycle that may still stall.
    localparam logic [3:0] WAIT_LAST = 4'(MEM_TIMEOUT - 1);

    state_t      state_reg, state_next;
    logic [2:0]  op_reg, op_next;
    logic [3:0]  wait_reg, wait_next;
    logic [15:0] count_reg;
    logic        illegal_reg, mem_error_reg;
    logic        retire, set_illegal, set_mem_error;

    // Next-state and event decode from present state, latched op and inputs.
    always_comb begin
        state_next    = state_reg;
        op_next       = op_reg;
        wait_next     = wait_reg;
        retire        = 1'b0;
        set_illegal   = 1'b0;
        set_mem_error = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (run) state_next = S_FETCH;
            end
            S_FETCH: begin
                state_next = S_DECODE;
            end
            S_DECODE: begin
                op_next = opclass;
                if (opclass <= OP_BRANCH) begin
                    state_next = S_EXECUTE;
                end else if (opclass == OP_HALT) begin
                    state_next = S_HALT;
                end else begin
                    state_next  = S_HALT;
                    set_illegal = 1'b1;
                end
            end
            S_EXECUTE: begin
                case (op_reg)
                    OP_ALU: state_next = S_WRITEBACK;
                    OP_LOAD, OP_STORE: begin
                        state_next = S_MEM;
                        wait_next  = 4'd0;
                    end
                    OP_BRANCH: begin
                        state_next = S_FETCH;
                        retire     = 1'b1;
                    end
                    default: begin
                        // Unreachable: only classes 0-3 enter EXECUTE.
                        state_next  = S_HALT;
                        set_illegal = 1'b1;
                    end
                endcase
            end
            S_MEM: begin
                // Completion wins over timeout when both happen together.
                if (mem_ready) begin
                    if (op_reg == OP_LOAD) begin
                        state_next = S_WRITEBACK;
                    end else begin
                        state_next = S_FETCH;
                        retire     = 1'b1;
                    end
                end else if (wait_reg == WAIT_LAST) begin
                    state_next    = S_HALT;
                    set_mem_error = 1'b1;
                end else begin
                    wait_next = wait_reg + 4'd1;
                end
            end
            S_WRITEBACK: begin
                state_next = S_FETCH;
                retire     = 1'b1;
            end
            S_HALT: begin
                state_next = S_HALT;
            end
            default: begin
                // Corrupted state code: park in HALT and flag it.
                state_next  = S_HALT;
                set_illegal = 1'b1;
            end
        endcase
    end

    // State, latched op, wait counter, retire counter and sticky flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= S_IDLE;
            op_reg        <= 3'd0;
            wait_reg      <= 4'd0;
            count_reg     <= 16'd0;
            illegal_reg   <= 1'b0;
            mem_error_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            op_reg    <= op_next;
            wait_reg  <= wait_next;
            if (retire)        count_reg     <= count_reg + 16'd1;
            if (set_illegal)   illegal_reg   <= 1'b1;
            if (set_mem_error) mem_error_reg <= 1'b1;
        end
    end

    // Stage enables: bit gi is high while the present state is code gi+1.
    logic [4:0] stage_en;
    for (genvar gi = 0; gi < 5; gi++) begin : g_stage
        assign stage_en[gi] = (3'(state_reg) == 3'(gi + 1));
    end

    assign en_Fetch     = stage_en[0];
    assign en_Decode    = stage_en[1];
    assign en_Execute   = stage_en[2];
    assign en_Mem       = stage_en[3];
    assign en_Writeback = stage_en[4];

    // Program memory is read ahead whenever the next cycle is a fetch.
    assign en_ProgMem  = (state_next == S_FETCH);
    assign pc_load     = (state_reg == S_EXECUTE) && (op_reg == OP_BRANCH) && branch_taken;
    assign state       = state_reg;
    assign halted      = (state_reg == S_HALT);
    assign illegal_op  = illegal_reg;
    assign mem_error   = mem_error_reg;
    assign instr_count = count_reg;

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: the stimulus side queues the
// hand-derived expected outputs for every driven cycle, and a monitor on
// the falling edge pops and compares them against the DUT outputs.
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        reset, run, branch_taken, mem_ready;
    logic [2:0]  opclass;
    logic        en_ProgMem, en_Fetch, en_Decode, en_Execute, en_Mem, en_Writeback;
    logic        pc_load, halted, illegal_op, mem_error;
    logic [2:0]  state;
    logic [15:0] instr_count;

    instr_sequencer #(.MEM_TIMEOUT(15)) dut (
        .clk(clk), .reset(reset), .run(run), .opclass(opclass),
        .branch_taken(branch_taken), .mem_ready(mem_ready),
        .en_ProgMem(en_ProgMem), .en_Fetch(en_Fetch), .en_Decode(en_Decode),
        .en_Execute(en_Execute), .en_Mem(en_Mem), .en_Writeback(en_Writeback),
        .pc_load(pc_load), .state(state), .halted(halted),
        .illegal_op(illegal_op), .mem_error(mem_error), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  st;
        logic [5:0]  en;   // {ProgMem, Fetch, Decode, Execute, Mem, Writeback}
        logic        pcl;
        logic        hlt;
        logic        ill;
        logic        merr;
        logic [15:0] cnt;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          checks   = 0;
    int          failures = 0;
    logic        exp_ill, exp_merr;
    logic [15:0] exp_cnt;

    localparam logic [2:0] IDLE = 3'd0, FETCH = 3'd1, DECODE = 3'd2, EXECUTE = 3'd3,
                           MEM = 3'd4, WB = 3'd5, HALT = 3'd6;

    function automatic logic [5:0] stage_vec(input logic [2:0] st, input logic pm);
        stage_vec = {pm, st == FETCH, st == DECODE, st == EXECUTE, st == MEM, st == WB};
    endfunction

    // Monitor: one comparison per queued cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            logic [28:0] act_v, exp_v;
            mon_e = sb.pop_front();
            act_v = {state, en_ProgMem, en_Fetch, en_Decode, en_Execute, en_Mem, en_Writeback,
                     pc_load, halted, illegal_op, mem_error, instr_count};
            exp_v = {mon_e.st, mon_e.en, mon_e.pcl, mon_e.hlt, mon_e.ill, mon_e.merr, mon_e.cnt};
            checks++;
            if (act_v !== exp_v) begin
                failures++;
                $display("FAIL %s: got st=%0d en=%b pcl=%b h=%b ill=%b merr=%b cnt=%h, want st=%0d en=%b pcl=%b h=%b ill=%b merr=%b cnt=%h",
                         mon_e.name, state,
                         {en_ProgMem, en_Fetch, en_Decode, en_Execute, en_Mem, en_Writeback},
                         pc_load, halted, illegal_op, mem_error, instr_count,
                         mon_e.st, mon_e.en, mon_e.pcl, mon_e.hlt, mon_e.ill, mon_e.merr, mon_e.cnt);
            end
        end
    end

    // Drive one cycle of inputs and queue the outputs expected during it.
    task automatic drive(input string nm, input logic r, input logic [2:0] oc, input logic bt,
                         input logic mr, input logic [2:0] est, input logic epm, input logic epcl);
        exp_t e;
        run = r; opclass = oc; branch_taken = bt; mem_ready = mr;
        e.name = nm; e.st = est; e.en = stage_vec(est, epm); e.pcl = epcl;
        e.hlt = (est == HALT); e.ill = exp_ill; e.merr = exp_merr; e.cnt = exp_cnt;
        sb.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; run = 1'b0; mem_ready = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_ill = 1'b0; exp_merr = 1'b0; exp_cnt = 16'h0000;
    endtask

    task automatic start(input string nm);
        drive(nm, 1, 0, 0, 0, IDLE, 1, 0);
    endtask

    task automatic op_alu(input string nm);
        drive(nm, 0, 0, 1, 0, FETCH, 0, 0);
        drive(nm, 0, 0, 1, 0, DECODE, 0, 0);
        drive(nm, 0, 0, 1, 0, EXECUTE, 0, 0);   // branch_taken high must not load PC
        drive(nm, 0, 0, 1, 0, WB, 1, 0);
        exp_cnt++;
        $display("TXN %s ALU count=%h", nm, exp_cnt);
    endtask

    task automatic op_mem(input string nm, input logic is_store, input int waits);
        logic [2:0] oc;
        oc = is_store ? 3'd2 : 3'd1;
        drive(nm, 0, oc, 0, 0, FETCH, 0, 0);
        drive(nm, 0, oc, 0, 0, DECODE, 0, 0);
        drive(nm, 0, oc, 0, 0, EXECUTE, 0, 0);
        for (int i = 0; i < waits; i++) drive(nm, 0, oc, 0, 0, MEM, 0, 0);
        if (is_store) begin
            drive(nm, 0, oc, 0, 1, MEM, 1, 0);
        end else begin
            drive(nm, 0, oc, 0, 1, MEM, 0, 0);
            drive(nm, 0, oc, 0, 0, WB, 1, 0);
        end
        exp_cnt++;
        $display("TXN %s %s waits=%0d count=%h", nm, is_store ? "STORE" : "LOAD", waits, exp_cnt);
    endtask

    task automatic op_branch(input string nm, input logic taken);
        drive(nm, 0, 3, taken, 0, FETCH, 0, 0);
        drive(nm, 0, 3, taken, 0, DECODE, 0, 0);
        drive(nm, 0, 3, taken, 0, EXECUTE, 1, taken);
        exp_cnt++;
        $display("TXN %s BRANCH taken=%0d count=%h", nm, taken, exp_cnt);
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; opclass = 3'd0; branch_taken = 1'b0; mem_ready = 1'b0;
        exp_ill = 1'b0; exp_merr = 1'b0; exp_cnt = 16'h0000;
        @(posedge clk); #1;
        do_reset();

        // Reset state and idling with run low.
        for (int i = 0; i < 3; i++) drive("idle", 0, 0, 1, 1, IDLE, 0, 0);
        $display("TXN reset idle");

        start("start1");
        op_alu("alu1");
        op_mem("load3", 1'b0, 3);
        op_mem("store3", 1'b1, 3);
        op_branch("br_taken", 1'b1);
        op_branch("br_not", 1'b0);
        op_mem("load14", 1'b0, 14);

        // LOAD with mem_ready never arriving: 15 MEM cycles then HALT.
        drive("tmo", 0, 1, 0, 0, FETCH, 0, 0);
        drive("tmo", 0, 1, 0, 0, DECODE, 0, 0);
        drive("tmo", 0, 1, 0, 0, EXECUTE, 0, 0);
        for (int i = 0; i < 15; i++) drive("tmo", 0, 1, 0, 0, MEM, 0, 0);
        exp_merr = 1'b1;
        drive("tmo_halt", 0, 1, 0, 1, HALT, 0, 0);
        drive("tmo_halt", 1, 1, 0, 1, HALT, 0, 0);
        $display("TXN timeout count=%h", exp_cnt);

        // HALT opcode: no count, no illegal flag, run toggling ignored.
        do_reset();
        drive("idle2", 0, 0, 0, 0, IDLE, 0, 0);
        start("start2");
        drive("halt_op", 0, 4, 0, 0, FETCH, 0, 0);
        drive("halt_op", 0, 4, 0, 0, DECODE, 0, 0);
        drive("halt_op", 1, 4, 0, 0, HALT, 0, 0);
        drive("halt_op", 0, 4, 0, 0, HALT, 0, 0);
        drive("halt_op", 1, 4, 0, 0, HALT, 0, 0);
        $display("TXN HALT op count=%h", exp_cnt);

        // Illegal opcode 6.
        do_reset();
        start("start3");
        drive("ill_op", 0, 6, 0, 0, FETCH, 0, 0);
        drive("ill_op", 0, 6, 0, 0, DECODE, 0, 0);
        exp_ill = 1'b1;
        drive("ill_op", 1, 6, 0, 0, HALT, 0, 0);
        drive("ill_op", 0, 6, 0, 0, HALT, 0, 0);
        $display("TXN illegal op");

        // Reset while stalled in MEM with five instructions retired.
        do_reset();
        start("start4");
        for (int i = 0; i < 5; i++) op_alu("pre_rst");
        drive("mid_mem", 0, 1, 0, 0, FETCH, 0, 0);
        drive("mid_mem", 0, 1, 0, 0, DECODE, 0, 0);
        drive("mid_mem", 0, 1, 0, 0, EXECUTE, 0, 0);
        for (int i = 0; i < 3; i++) drive("mid_mem", 0, 1, 0, 0, MEM, 0, 0);
        do_reset();
        drive("post_rst", 0, 0, 0, 0, IDLE, 0, 0);
        $display("TXN reset during MEM wait");

        // Counter wrap: preload 0xFF00 while idle, then retire 256 ALU ops.
        force dut.count_reg = 16'hFF00;
        #1;
        release dut.count_reg;
        exp_cnt = 16'hFF00;
        drive("preload", 0, 0, 0, 0, IDLE, 0, 0);
        start("start5");
        for (int i = 0; i < 256; i++) op_alu("wrap");
        drive("wrap_end", 0, 0, 0, 0, FETCH, 0, 0);

        @(negedge clk); #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d queued entries, want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
